hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MDU_LAT, default 34, cycles an E-stage mul/div instruction occupies E (legal range 2..63).
REQ-002 Port: clk_i  in  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: D_rs1_i / D_rs2_i  in  5 each  source registers of the instruction in D.
REQ-005 Port: D_use_rs1_i / D_use_rs2_i  in  1 each  D instruction actually reads rs1/rs2.
REQ-006 Port: DD_load_op_i  in  `LOAD_WIDTH  load op of the instruction in E; nonzero means load.
REQ-007 Port: DD_dstE_i  in  5  destination register of the instruction in E.
REQ-008 Port: E_mispredict_i  in  1  E resolved a branch/jalr with nPC different from the predicted PC.
REQ-009 Port: E_mdu_start_i  in  1  instruction in E is a multi-cycle mul/div, first cycle in E.
REQ-010 Port: M_req_i / M_ack_i  in  1 each  data-memory request from M and its completion.
REQ-011 Port: F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o, M_stall_o, M_bubble_o, W_bubble_o  out  1 each  pipeline-register controls.
REQ-012 Port: stall_cnt_o  out  `XLEN  saturating count of cycles with F_stall_o=1.
REQ-013 Port: busy_o  out  1  FSM not in IDLE.

Function
REQ-014 FSM states: IDLE, MDU_WAIT; a 6-bit down-counter mdu_cnt is held in MDU_WAIT.
REQ-015 Control outputs are combinational from the registered state and current inputs; stall_cnt_o, the state and mdu_cnt are registered.
REQ-016 Priority, highest first: memory wait > MDU wait > mispredict > load-use; only the highest active condition drives the outputs.
REQ-017 Memory wait (M_req_i=1, M_ack_i=0): F, D, E and M stall, W_bubble_o=1, all other outputs 0; mdu_cnt is frozen.
REQ-018 IDLE with E_mdu_start_i=1 and no memory wait: go to MDU_WAIT, load mdu_cnt=MDU_LAT-2; this cycle F, D and E stall, M_bubble_o=1.
REQ-019 MDU_WAIT: F, D and E stall, M_bubble_o=1; mdu_cnt decrements each non-memory-wait cycle; in the cycle mdu_cnt==0, no stall and no bubble; next state is IDLE.
REQ-020 Total E occupancy of a mul/div instruction without memory waits is exactly MDU_LAT cycles.
REQ-021 In MDU_WAIT, E_mdu_start_i and E_mispredict_i are ignored.
REQ-022 Mispredict (state IDLE, no higher condition): D_bubble_o=1, E_bubble_o=1, no stall; this squashes the two younger instructions.
REQ-023 Load-use: DD_load_op_i!=0, DD_dstE_i!=0, and DD_dstE_i equals D_rs1_i (with D_use_rs1_i) or D_rs2_i (with D_use_rs2_i): F and D stall, E_bubble_o=1 for exactly one cycle.
REQ-024 A load-use hazard against x0 never stalls.
REQ-025 Mispredict together with load-use: mispredict wins, with no stall.
REQ-026 stall_cnt_o increments by 1 on each cycle where F_stall_o=1 and holds at all-ones (no wrap).
REQ-027 A bubble and a stall are never both asserted for the same register.

Reset
REQ-028 While rst_n=0: state=IDLE, mdu_cnt=0, stall_cnt_o=0.
REQ-029 While rst_n=0: all stall outputs=0, and D/E/M/W bubble outputs=1, so the downstream registers load nops.
REQ-030 Reset asserted mid-MDU_WAIT or mid-memory-wait aborts immediately; the FSM restarts in IDLE after release.

Structure
REQ-031 `LOAD_WIDTH, `XLEN and the FSM state encoding live in the shared define.v include.
REQ-032 MDU_LAT is a module parameter.
REQ-033 One sub-module, hazard_detect, holds the purely combinational load-use compare.
REQ-034 The FSM, counters and priority mux reside in hazard_ctrl.

Verification
REQ-035 Load-use: load x5 in E, D reads x5 -> one cycle of F_stall=D_stall=E_bubble=1, then all 0; stall_cnt_o=1.
REQ-036 x0 case: DD_dstE=0 with a load in E, D rs1=0 -> no stall.
REQ-037 MDU: E_mdu_start_i pulse with MDU_LAT=34 -> E_stall high 33 cycles, released on the 34th; busy_o drops after that cycle.
REQ-038 Memory wait inside MDU: M_req=1, M_ack=0 for 5 cycles at count 10 -> M_stall and W_bubble for 5 cycles; total E occupancy 39 cycles.
REQ-039 Mispredict together with load-use -> D_bubble=E_bubble=1, F_stall=0; stall_cnt_o unchanged.
REQ-040 Reset: rst_n low at MDU count 20 -> outputs take reset values immediately; after release, state is IDLE with no stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared widths and FSM state encoding for the hazard controller
package hazard_ctrl_pkg;
    localparam int XLEN       = 32;
    localparam int LOAD_WIDTH = 3;
    typedef enum logic {IDLE = 1'b0, MDU_WAIT = 1'b1} state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from the pipeline and the stall/bubble controls back to it
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;
    logic [4:0]            D_rs1_i, D_rs2_i, DD_dstE_i;
    logic                  D_use_rs1_i, D_use_rs2_i;
    logic [LOAD_WIDTH-1:0] DD_load_op_i;
    logic                  E_mispredict_i, E_mdu_start_i, M_req_i, M_ack_i;
    logic                  F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o;
    logic                  M_stall_o, M_bubble_o, W_bubble_o, busy_o;
    logic [XLEN-1:0]       stall_cnt_o;
    modport master (
        output D_rs1_i, D_rs2_i, DD_dstE_i, D_use_rs1_i, D_use_rs2_i, DD_load_op_i,
               E_mispredict_i, E_mdu_start_i, M_req_i, M_ack_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
               M_stall_o, M_bubble_o, W_bubble_o, busy_o, stall_cnt_o
    );
    modport slave (
        input  D_rs1_i, D_rs2_i, DD_dstE_i, D_use_rs1_i, D_use_rs2_i, DD_load_op_i,
               E_mispredict_i, E_mdu_start_i, M_req_i, M_ack_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
               M_stall_o, M_bubble_o, W_bubble_o, busy_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: load-use compare between the load in E and the sources read in D
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic                  use_rs1_i,
    input  logic                  use_rs2_i,
    input  logic [LOAD_WIDTH-1:0] load_op_i,
    input  logic [4:0]            dst_i,
    output logic                  load_use_o
);
    // x0 is never a real dependency
    assign load_use_o = (|load_op_i) && (|dst_i) &&
                        ((use_rs1_i && rs1_i == dst_i) || (use_rs2_i && rs2_i == dst_i));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: prioritised stall/bubble generation with multi-cycle mul/div wait FSM
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 34
) (
    input  logic          clk_i,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hif
);
    state_e          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic            mem_wait, load_use;
    logic [7:0]      ctrl;

    hazard_detect u_detect (
        .rs1_i      (hif.D_rs1_i),
        .rs2_i      (hif.D_rs2_i),
        .use_rs1_i  (hif.D_use_rs1_i),
        .use_rs2_i  (hif.D_use_rs2_i),
        .load_op_i  (hif.DD_load_op_i),
        .dst_i      (hif.DD_dstE_i),
        .load_use_o (load_use)
    );

    assign mem_wait = hif.M_req_i & ~hif.M_ack_i;

    // ctrl = {F,D,E,M stall, D,E,M,W bubble}
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = 8'b0000_0000;
        if (mem_wait)
            ctrl = 8'b1111_0001;
        else if (state_q == MDU_WAIT) begin
            if (cnt_q == 6'd0)
                state_d = IDLE;
            else begin
                ctrl  = 8'b1110_0010;
                cnt_d = cnt_q - 6'd1;
            end
        end else if (hif.E_mdu_start_i) begin
            ctrl    = 8'b1110_0010;
            state_d = MDU_WAIT;
            cnt_d   = 6'(MDU_LAT - 2);
        end else if (hif.E_mispredict_i)
            ctrl = 8'b0000_1100;
        else if (load_use)
            ctrl = 8'b1100_0100;
        // nops flow downstream while reset is held
        if (!rst_n)
            ctrl = 8'b0000_1111;
        stall_cnt_d = (ctrl[7] && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign {hif.F_stall_o, hif.D_stall_o, hif.E_stall_o, hif.M_stall_o,
            hif.D_bubble_o, hif.E_bubble_o, hif.M_bubble_o, hif.W_bubble_o} = ctrl;
    assign hif.busy_o      = state_q != IDLE;
    assign hif.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks against an occupancy-based reference model
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;
    localparam int LAT = 34;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    hazard_ctrl_if hif ();
    hazard_ctrl #(.MDU_LAT(LAT)) dut (.clk_i(clk_i), .rst_n(rst_n), .hif(hif));

    int cmp_n = 0, err_n = 0;
    int left = 0;
    logic [XLEN-1:0] scnt = '0;
    int es_n = 0, ms_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctrl_obs();
        return {hif.F_stall_o, hif.D_stall_o, hif.E_stall_o, hif.M_stall_o,
                hif.D_bubble_o, hif.E_bubble_o, hif.M_bubble_o, hif.W_bubble_o};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic [LOAD_WIDTH-1:0] ld, input logic [4:0] dst,
                          input logic mis, input logic start, input logic mreq, input logic mack);
        hif.D_rs1_i = rs1; hif.D_rs2_i = rs2; hif.D_use_rs1_i = u1; hif.D_use_rs2_i = u2;
        hif.DD_load_op_i = ld; hif.DD_dstE_i = dst; hif.E_mispredict_i = mis;
        hif.E_mdu_start_i = start; hif.M_req_i = mreq; hif.M_ack_i = mack;
    endtask

    task automatic quiet();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // called at posedge+1 with inputs set; compares mid-cycle, advances the model, returns at next posedge+1
    task automatic tick();
        logic [7:0] e;
        logic mw, lu;
        int nleft;
        #3;
        e = 8'h00;
        nleft = left;
        mw = hif.M_req_i && !hif.M_ack_i;
        lu = hif.DD_load_op_i != 0 && hif.DD_dstE_i != 0 &&
             ((hif.D_use_rs1_i && hif.D_rs1_i == hif.DD_dstE_i) ||
              (hif.D_use_rs2_i && hif.D_rs2_i == hif.DD_dstE_i));
        if (mw) e = 8'b1111_0001;
        else if (left > 1) begin e = 8'b1110_0010; nleft = left - 1; end
        else if (left == 1) nleft = 0;
        else if (hif.E_mdu_start_i) begin e = 8'b1110_0010; nleft = LAT - 1; end
        else if (hif.E_mispredict_i) e = 8'b0000_1100;
        else if (lu) e = 8'b1100_0100;
        chk("ctrl", {24'd0, ctrl_obs()}, {24'd0, e});
        chk("busy", {31'd0, hif.busy_o}, {31'd0, left > 0});
        chk("stall_cnt", hif.stall_cnt_o, scnt);
        if (hif.E_stall_o) es_n++;
        if (hif.M_stall_o) ms_n++;
        left = nleft;
        if (e[7] && scnt != '1) scnt = scnt + 1;
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {24'd0, ctrl_obs()}, 32'h0F);
        chk("rst_busy", {31'd0, hif.busy_o}, 32'd0);
        chk("rst_cnt", hif.stall_cnt_o, 32'd0);
        left = 0;
        scnt = '0;
        @(posedge clk_i); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        quiet();
        #3;
        chk("rst0_ctrl", {24'd0, ctrl_obs()}, 32'h0F);
        chk("rst0_cnt", hif.stall_cnt_o, 32'd0);
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        // load x5 in E, D reads x5
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 3'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        quiet(); tick();
        chk("lu_cnt", hif.stall_cnt_o, 32'd1);
        // load into x0 never stalls
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 3'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        // rs2 path
        set_in(5'd1, 5'd9, 1'b0, 1'b1, 3'd4, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        // mispredict beats load-use
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 3'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("mis_fstall", {31'd0, hif.F_stall_o}, 32'd0);
        // plain MDU occupancy
        es_n = 0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        quiet();
        for (int i = 0; i < 40; i++) tick();
        chk("mdu_estall", es_n, LAT - 1);
        // MDU with a 5-cycle memory wait in the middle
        es_n = 0; ms_n = 0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        quiet();
        for (int i = 0; i < 23; i++) tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        quiet();
        for (int i = 0; i < 40; i++) tick();
        chk("mdu_mw_estall", es_n, LAT - 1 + 5);
        chk("mdu_mw_mstall", ms_n, 5);
        // reset aborts an MDU wait
        set_in(5'd0, 5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        quiet();
        for (int i = 0; i < 13; i++) tick();
        do_reset();
        tick();
        // reset aborts a memory wait
        set_in(5'd0, 5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick(); tick();
        do_reset();
        quiet(); tick();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 1) == 1) ? LOAD_WIDTH'($urandom) : '0, 5'($urandom_range(0, 3)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                   $urandom_range(0, 5) == 0, 1'($urandom));
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
